// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: opcode constants, the
// load/store type encoding and the opcode decoder used by mem_stage.
package mem_pkg;

    localparam logic [5:0] OPC_LW  = 6'b100011;
    localparam logic [5:0] OPC_LH  = 6'b100001;
    localparam logic [5:0] OPC_LHU = 6'b100101;
    localparam logic [5:0] OPC_LB  = 6'b100000;
    localparam logic [5:0] OPC_LBU = 6'b100100;
    localparam logic [5:0] OPC_SW  = 6'b101011;
    localparam logic [5:0] OPC_SH  = 6'b101001;
    localparam logic [5:0] OPC_SB  = 6'b101000;

    typedef enum logic [3:0] {
        MEM_NONE,
        MEM_LW,
        MEM_LH,
        MEM_LHU,
        MEM_LB,
        MEM_LBU,
        MEM_SW,
        MEM_SH,
        MEM_SB
    } mem_op_t;

    function automatic mem_op_t decode_mem_op(input logic [5:0] opcode);
        case (opcode)
            OPC_LW:  return MEM_LW;
            OPC_LH:  return MEM_LH;
            OPC_LHU: return MEM_LHU;
            OPC_LB:  return MEM_LB;
            OPC_LBU: return MEM_LBU;
            OPC_SW:  return MEM_SW;
            OPC_SH:  return MEM_SH;
            OPC_SB:  return MEM_SB;
            default: return MEM_NONE;
        endcase
    endfunction

    function automatic logic is_load_op(input mem_op_t op);
        return (op == MEM_LW) || (op == MEM_LH) || (op == MEM_LHU) ||
               (op == MEM_LB) || (op == MEM_LBU);
    endfunction

    function automatic logic is_store_op(input mem_op_t op);
        return (op == MEM_SW) || (op == MEM_SH) || (op == MEM_SB);
    endfunction

endpackage

// File: rtl/dm_ext.sv
// Load-data extractor: picks the addressed byte/halfword out of the read
// word and sign- or zero-extends it according to the load type.
import mem_pkg::*;

module dm_ext (
    input  mem_op_t     op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] ext
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Select the lane addressed by the low address bits, then extend it.
    always_comb begin
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        case (op)
            MEM_LW:  ext = rdata;
            MEM_LH:  ext = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: ext = {16'h0000, half_sel};
            MEM_LB:  ext = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: ext = {24'h000000, byte_sel};
            default: ext = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: word-organised data memory with byte-lane writes,
// combinational read, store-data forwarding from W and the M/W register.
// Optional macro MEM_ALIGN_CHECK_EN enables the misaligned-access flag
// exc_M and suppresses the faulting access; without it exc_M is 0.
// DM_WORDS is expected to be a power of two so the index wraps cleanly.
import mem_pkg::*;

module mem_stage #(
    parameter int DM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_M,
    input  logic [31:0] PC_M,
    input  logic [31:0] AO_M,
    input  logic [31:0] RT_M,
    input  logic [31:0] HILO_M,
    input  logic [31:0] Result_W,
    input  logic        rt_Mforward,
    output logic [31:0] instr_W,
    output logic [31:0] PC_W,
    output logic [31:0] AO_W,
    output logic [31:0] HILO_W,
    output logic [31:0] DR_W,
    output logic        exc_M
);

    localparam int AW = $clog2(DM_WORDS);

    logic [31:0]   dm [DM_WORDS];
    mem_op_t       op;
    logic [AW-1:0] idx;
    logic [31:0]   rdata;
    logic [31:0]   wd;
    logic [31:0]   lane_data;
    logic [31:0]   load_ext;
    logic [3:0]    be;
    logic          store_en;
    logic          load_en;

    assign op    = decode_mem_op(instr_M[31:26]);
    assign idx   = AO_M[AW+1:2];
    assign rdata = dm[idx];
    assign wd    = rt_Mforward ? Result_W : RT_M;

`ifdef MEM_ALIGN_CHECK_EN
    assign exc_M = (((op == MEM_LW) || (op == MEM_SW)) && (AO_M[1:0] != 2'b00)) ||
                   (((op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH)) && AO_M[0]);
`else
    assign exc_M = 1'b0;
`endif

    assign store_en = is_store_op(op) && !exc_M;
    assign load_en  = is_load_op(op) && !exc_M;

    // Byte enables and lane replication of the store data.
    always_comb begin
        be        = 4'b0000;
        lane_data = wd;
        case (op)
            MEM_SW: be = 4'b1111;
            MEM_SH: begin
                be        = AO_M[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wd[15:0]}};
            end
            MEM_SB: begin
                be        = 4'b0001 << AO_M[1:0];
                lane_data = {4{wd[7:0]}};
            end
            default: ;
        endcase
    end

    dm_ext u_dm_ext (
        .op      (op),
        .addr_lo (AO_M[1:0]),
        .rdata   (rdata),
        .ext     (load_ext)
    );

    // Data memory: cleared while in reset, otherwise byte-lane writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                dm[i] <= 32'h0000_0000;
            end
        end else if (store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    dm[idx][8*b +: 8] <= lane_data[8*b +: 8];
                end
            end
        end
    end

    // M/W pipeline register, always advancing; DR_W is zero unless a load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_W <= 32'h0000_0000;
            PC_W    <= 32'h0000_0000;
            AO_W    <= 32'h0000_0000;
            HILO_W  <= 32'h0000_0000;
            DR_W    <= 32'h0000_0000;
        end else begin
            instr_W <= instr_M;
            PC_W    <= PC_M;
            AO_W    <= AO_M;
            HILO_W  <= HILO_M;
            DR_W    <= load_en ? load_ext : 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: byte-addressed little-endian reference memory,
// per-cycle comparison of all outputs, plus directed literal expectations.
module tb_mem_stage;

    localparam int DM_BYTES = 4096 * 4;

    localparam logic [5:0] T_NOP = 6'b000000;
    localparam logic [5:0] T_LW  = 6'b100011;
    localparam logic [5:0] T_LH  = 6'b100001;
    localparam logic [5:0] T_LHU = 6'b100101;
    localparam logic [5:0] T_LB  = 6'b100000;
    localparam logic [5:0] T_LBU = 6'b100100;
    localparam logic [5:0] T_SW  = 6'b101011;
    localparam logic [5:0] T_SH  = 6'b101001;
    localparam logic [5:0] T_SB  = 6'b101000;

    logic        clk;
    logic        reset;
    logic [31:0] instr_M;
    logic [31:0] PC_M;
    logic [31:0] AO_M;
    logic [31:0] RT_M;
    logic [31:0] HILO_M;
    logic [31:0] Result_W;
    logic        rt_Mforward;
    logic [31:0] instr_W;
    logic [31:0] PC_W;
    logic [31:0] AO_W;
    logic [31:0] HILO_W;
    logic [31:0] DR_W;
    logic        exc_M;

    int checks;
    int failures;

    logic [7:0]  mbyte [DM_BYTES];
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic [31:0] exp_ao;
    logic [31:0] exp_hilo;
    logic [31:0] exp_dr;
    logic [31:0] model_wd;

    mem_stage dut (
        .clk         (clk),
        .reset       (reset),
        .instr_M     (instr_M),
        .PC_M        (PC_M),
        .AO_M        (AO_M),
        .RT_M        (RT_M),
        .HILO_M      (HILO_M),
        .Result_W    (Result_W),
        .rt_Mforward (rt_Mforward),
        .instr_W     (instr_W),
        .PC_W        (PC_W),
        .AO_W        (AO_W),
        .HILO_W      (HILO_W),
        .DR_W        (DR_W),
        .exc_M       (exc_M)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model helpers: access size in bytes (0 = not a memory op).
    function automatic int acc_size(input logic [5:0] opc);
        case (opc)
            T_LW, T_SW:        return 4;
            T_LH, T_LHU, T_SH: return 2;
            T_LB, T_LBU, T_SB: return 1;
            default:           return 0;
        endcase
    endfunction

    function automatic bit is_ld(input logic [5:0] opc);
        return (opc[5:3] == 3'b100) && (acc_size(opc) != 0);
    endfunction

    function automatic bit is_st(input logic [5:0] opc);
        return (opc[5:3] == 3'b101) && (acc_size(opc) != 0);
    endfunction

    function automatic bit model_exc(input logic [5:0] opc, input logic [31:0] ao);
`ifdef MEM_ALIGN_CHECK_EN
        int n;
        n = acc_size(opc);
        return ((n == 4) && (ao[1:0] != 2'b00)) || ((n == 2) && ao[0]);
`else
        return 1'b0;
`endif
    endfunction

    // First byte of an access: address wrapped, then aligned to its size.
    function automatic int base_addr(input logic [5:0] opc, input logic [31:0] ao);
        int a;
        int n;
        n = acc_size(opc);
        a = int'(ao % DM_BYTES);
        if (n > 1) a = a - (a % n);
        return a;
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] opc, input logic [31:0] ao);
        logic [31:0] v;
        int n;
        int a;
        v = 32'h0;
        if (!is_ld(opc) || model_exc(opc, ao)) return 32'h0;
        n = acc_size(opc);
        a = base_addr(opc, ao);
        for (int k = 0; k < n; k++) v[8*k +: 8] = mbyte[a + k];
        if ((opc == T_LH) && v[15]) v[31:16] = 16'hFFFF;
        if ((opc == T_LB) && v[7])  v[31:8]  = 24'hFFFFFF;
        return v;
    endfunction

    assign model_wd = rt_Mforward ? Result_W : RT_M;

    // Reference model state: expected W values and memory image.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DM_BYTES; i++) mbyte[i] <= 8'h00;
            exp_instr <= 32'h0;
            exp_pc    <= 32'h0;
            exp_ao    <= 32'h0;
            exp_hilo  <= 32'h0;
            exp_dr    <= 32'h0;
        end else begin
            exp_instr <= instr_M;
            exp_pc    <= PC_M;
            exp_ao    <= AO_M;
            exp_hilo  <= HILO_M;
            exp_dr    <= model_load(instr_M[31:26], AO_M);
            if (is_st(instr_M[31:26]) && !model_exc(instr_M[31:26], AO_M)) begin
                for (int k = 0; k < acc_size(instr_M[31:26]); k++) begin
                    mbyte[base_addr(instr_M[31:26], AO_M) + k] <= model_wd[8*k +: 8];
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    initial begin
        @(negedge clk);
        forever begin
            @(negedge clk);
            check_output("cmp_instr_W", instr_W, exp_instr);
            check_output("cmp_PC_W",    PC_W,    exp_pc);
            check_output("cmp_AO_W",    AO_W,    exp_ao);
            check_output("cmp_HILO_W",  HILO_W,  exp_hilo);
            check_output("cmp_DR_W",    DR_W,    exp_dr);
            check_output("cmp_exc_M",   {31'h0, exc_M},
                         {31'h0, model_exc(instr_M[31:26], AO_M)});
        end
    end

    // Drive one instruction into M just after a rising edge.
    task automatic apply_stimulus(input logic [5:0] opc, input logic [31:0] ao,
                                  input logic [31:0] rt, input logic fwd,
                                  input logic [31:0] resw);
        @(posedge clk);
        #1;
        instr_M     = {opc, 5'd3, 5'd8, 16'h1234};
        PC_M        = PC_M + 32'd4;
        AO_M        = ao;
        RT_M        = rt;
        HILO_M      = ao ^ 32'h5A5A_0F0F;
        Result_W    = resw;
        rt_Mforward = fwd;
    endtask

    task automatic op(input logic [5:0] opc, input logic [31:0] ao, input logic [31:0] rt);
        apply_stimulus(opc, ao, rt, 1'b0, 32'h0);
    endtask

    // Issue a load, then a nop; after the nop is driven the load result is in DR_W.
    task automatic load_check(input string name, input logic [5:0] opc,
                              input logic [31:0] ao, input logic [31:0] expected);
        op(opc, ao, 32'h0);
        op(T_NOP, 32'h0, 32'h0);
        check_output(name, DR_W, expected);
    endtask

    initial begin
        $display("[TB] mem_stage bench start");
        checks      = 0;
        failures    = 0;
        reset       = 1'b0;
        instr_M     = 32'h0;
        PC_M        = 32'h0000_3000;
        AO_M        = 32'h0;
        RT_M        = 32'h0;
        HILO_M      = 32'h0;
        Result_W    = 32'h0;
        rt_Mforward = 1'b0;

        #7;
        check_output("rst_instr_W", instr_W, 32'h0);
        check_output("rst_PC_W",    PC_W,    32'h0);
        check_output("rst_DR_W",    DR_W,    32'h0);
        #1 reset = 1'b1;

        op(T_SW, 32'h10, 32'hDEADBEEF);
        load_check("lw_0x10", T_LW, 32'h10, 32'hDEADBEEF);

        op(T_SB, 32'h13, 32'h0000_00A5);
        load_check("lb_0x13",  T_LB,  32'h13, 32'hFFFF_FFA5);
        load_check("lbu_0x13", T_LBU, 32'h13, 32'h0000_00A5);
        load_check("lw_after_sb", T_LW, 32'h10, 32'hA5AD_BEEF);
        load_check("lb_0x10",  T_LB,  32'h10, 32'hFFFF_FFEF);
        load_check("lbu_0x11", T_LBU, 32'h11, 32'h0000_00BE);
        load_check("lh_0x12",  T_LH,  32'h12, 32'hFFFF_A5AD);
        load_check("lhu_0x10", T_LHU, 32'h10, 32'h0000_BEEF);

        op(T_SH, 32'h22, 32'h0000_8001);
        load_check("lh_0x22",  T_LH,  32'h22, 32'hFFFF_8001);
        load_check("lhu_0x22", T_LHU, 32'h22, 32'h0000_8001);
        load_check("lh_0x20",  T_LH,  32'h20, 32'h0000_0000);

        apply_stimulus(T_SW, 32'h40, 32'h0, 1'b1, 32'h1234_5678);
        load_check("lw_fwd_0x40", T_LW, 32'h40, 32'h1234_5678);

        load_check("lw_wrap_0x4010", T_LW, 32'h4010, 32'hA5AD_BEEF);

        op(T_LW, 32'h10, 32'h0);
        op(T_SW, 32'h80, 32'h7777_7777);
        op(T_NOP, 32'h0, 32'h0);
        check_output("dr_zero_store", DR_W, 32'h0);

        op(T_SW, 32'h11, 32'hCAFE_F00D);
        #1;
`ifdef MEM_ALIGN_CHECK_EN
        check_output("exc_sw_0x11", {31'h0, exc_M}, 32'h1);
        load_check("lw_after_bad_sw", T_LW, 32'h10, 32'hA5AD_BEEF);
        load_check("lw_bad_align", T_LW, 32'h12, 32'h0);
`else
        check_output("exc_sw_0x11", {31'h0, exc_M}, 32'h0);
        load_check("lw_after_bad_sw", T_LW, 32'h10, 32'hCAFE_F00D);
        load_check("lw_misaligned", T_LW, 32'h12, 32'hCAFE_F00D);
`endif

        op(T_SW, 32'h50, 32'h0BAD_CAFE);
        op(T_LW, 32'h50, 32'h0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_output("mid_rst_instr_W", instr_W, 32'h0);
        check_output("mid_rst_PC_W",    PC_W,    32'h0);
        check_output("mid_rst_AO_W",    AO_W,    32'h0);
        check_output("mid_rst_HILO_W",  HILO_W,  32'h0);
        check_output("mid_rst_DR_W",    DR_W,    32'h0);
        @(negedge clk);
        #2 reset = 1'b1;
        load_check("lw_0x10_post_rst", T_LW, 32'h10, 32'h0);
        load_check("lw_0x50_post_rst", T_LW, 32'h50, 32'h0);

        op(T_SW, 32'h10, 32'h600D_F00D);
        load_check("lw_resume", T_LW, 32'h10, 32'h600D_F00D);

        op(T_NOP, 32'h0, 32'h0);
        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
